// File: rtl/gact_seq_loader.sv
//------------------------------------------------------------------------------
// Module  : gact_seq_loader
// Brief   : Unpacks ASCII sequence words into 4-bit GACT nucleotide codes with
//           write addresses; optional complement / reverse-byte-order strands.
//           Macro GACT_SEQ_LOADER_SOFTMASK_EN: lowercase a/c/g/t map to N.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gact_seq_loader #(
  parameter int IN_W  = 64,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] seq_len,
  input  logic             complement,
  input  logic             reverse,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       nt_out,
  output logic [LEN_W-1:0] nt_addr,
  output logic             nt_valid,
  input  logic             nt_ready,
  output logic             busy,
  output logic             done
);

  localparam int B  = IN_W / 8;
  localparam int BW = (B > 1) ? $clog2(B) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [IN_W-1:0]  r_word;
  logic [BW-1:0]    r_byte_idx;
  logic [LEN_W-1:0] r_addr;
  logic [LEN_W-1:0] r_len;
  logic             r_comp;
  logic             r_rev;

  logic [BW-1:0]    w_sel;
  logic [7:0]       w_char;
  logic [2:0]       w_base;
  logic [2:0]       w_code;
  logic             w_last_nt;
  logic             w_last_byte;

  function automatic logic [2:0] base_code(input logic [7:0] ch);
    logic [2:0] code;
    code = 3'd0;
    case (ch)
      8'h41: code = 3'd1;
      8'h43: code = 3'd2;
      8'h47: code = 3'd3;
      8'h54: code = 3'd4;
`ifdef GACT_SEQ_LOADER_SOFTMASK_EN
      default: code = 3'd0;
`else
      8'h61: code = 3'd1;
      8'h63: code = 3'd2;
      8'h67: code = 3'd3;
      8'h74: code = 3'd4;
      default: code = 3'd0;
`endif
    endcase
    return code;
  endfunction

  // Reverse mode walks the word from the top byte down.
  assign w_sel  = r_rev ? (BW'(B - 1) - r_byte_idx) : r_byte_idx;
  assign w_char = 8'(r_word >> {w_sel, 3'b000});
  assign w_base = base_code(w_char);
  // Codes A=1..T=4 are laid out so that complement is 5 - code; N stays 0.
  assign w_code = (r_comp && (w_base != 3'd0)) ? (3'd5 - w_base) : w_base;

  assign w_last_nt   = (r_addr == (r_len - LEN_W'(1)));
  assign w_last_byte = (r_byte_idx == BW'(B - 1));

  assign in_ready = (r_state == S_FETCH);
  assign nt_valid = (r_state == S_EMIT);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign nt_out   = nt_valid ? {1'b0, w_code} : 4'd0;
  assign nt_addr  = r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_byte_idx <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_comp     <= 1'b0;
      r_rev      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= seq_len;
            r_comp  <= complement;
            r_rev   <= reverse;
            r_addr  <= '0;
            r_state <= (seq_len == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            r_word     <= in_data;
            r_byte_idx <= '0;
            r_state    <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (nt_ready) begin
            // The final address is held so the write address stays meaningful.
            if (w_last_nt) begin
              r_state <= S_DONE;
            end else begin
              r_addr     <= r_addr + LEN_W'(1);
              r_byte_idx <= r_byte_idx + BW'(1);
              if (w_last_byte) begin
                r_state <= S_FETCH;
              end
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gact_seq_loader.sv
//------------------------------------------------------------------------------
// Module  : tb_gact_seq_loader
// Brief   : Scoreboard bench for gact_seq_loader (IN_W=64, LEN_W=16).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gact_seq_loader;

  localparam int IN_W  = 64;
  localparam int LEN_W = 16;
  localparam int B     = IN_W / 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] seq_len = '0;
  logic             complement = 1'b0;
  logic             reverse = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       nt_out;
  logic [LEN_W-1:0] nt_addr;
  logic             nt_valid;
  logic             nt_ready = 1'b1;
  logic             busy;
  logic             done;

  gact_seq_loader #(.IN_W(IN_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len),
    .complement(complement), .reverse(reverse),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .nt_out(nt_out), .nt_addr(nt_addr), .nt_valid(nt_valid), .nt_ready(nt_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [LEN_W+3:0] sb[$];
  logic [IN_W-1:0]  wq[$];
  int accepts = 0;
  int done_cnt = 0;
  int inrdy_seen = 0;
  int ntv_seen = 0;
  int last_acc_cyc = 0;
  bit toggle_mode = 1'b0;
  bit check_done_timing = 1'b0;
  bit acc_pending = 1'b0;
  bit stalled = 1'b0;
  logic [3:0]       hold_nt;
  logic [LEN_W-1:0] hold_addr;
  logic [7:0] alph [12] = '{8'h41, 8'h43, 8'h47, 8'h54, 8'h4E, 8'h61,
                            8'h63, 8'h67, 8'h74, 8'h6E, 8'h58, 8'h2D};

  always @(posedge clk) cyc++;

  // Word source and consumer back-pressure, updated just after each edge.
  always @(posedge clk) begin
    #1;
    in_valid = (wq.size() > 0);
    in_data  = (wq.size() > 0) ? wq[0] : '0;
    nt_ready = toggle_mode ? ~nt_ready : 1'b1;
  end

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [LEN_W+3:0] exp;
    if (rst) begin
      acc_pending = 1'b0;
      stalled     = 1'b0;
    end else begin
      if (acc_pending) begin
        tests++;
        if (nt_valid !== 1'b1) begin
          fails++;
          $display("FAIL first_nt_latency: nt_valid=%b required 1", nt_valid);
        end
        acc_pending = 1'b0;
      end
      if (in_ready) inrdy_seen++;
      if (nt_valid) ntv_seen++;
      if (in_valid && in_ready) begin
        accepts++;
        void'(wq.pop_front());
        acc_pending = 1'b1;
      end
      if (stalled) begin
        tests++;
        if (nt_valid !== 1'b1 || nt_out !== hold_nt || nt_addr !== hold_addr) begin
          fails++;
          $display("FAIL stall_stable: got v=%b nt=%0d addr=%0d required v=1 nt=%0d addr=%0d",
                   nt_valid, nt_out, nt_addr, hold_nt, hold_addr);
        end
      end
      stalled = 1'b0;
      if (nt_valid && !nt_ready) begin
        stalled   = 1'b1;
        hold_nt   = nt_out;
        hold_addr = nt_addr;
      end
      if (nt_valid && nt_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL nt_extra: got addr=%0d nt=%0d required none", nt_addr, nt_out);
        end else begin
          exp = sb.pop_front();
          if ({nt_addr, nt_out} !== exp) begin
            fails++;
            $display("FAIL nt_data: got addr=%0d nt=%0d required addr=%0d nt=%0d",
                     nt_addr, nt_out, exp[LEN_W+3:4], exp[3:0]);
          end
        end
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (check_done_timing) begin
          tests++;
          if (cyc != last_acc_cyc + 1) begin
            fails++;
            $display("FAIL done_timing: got cycle %0d required %0d", cyc, last_acc_cyc + 1);
          end
        end
      end
    end
  end

  function automatic logic [3:0] mdl(input logic [7:0] ch, input bit comp);
    logic [3:0] c;
    c = 4'd0;
    if (ch == "A") c = 4'd1;
    if (ch == "C") c = 4'd2;
    if (ch == "G") c = 4'd3;
    if (ch == "T") c = 4'd4;
`ifndef GACT_SEQ_LOADER_SOFTMASK_EN
    if (ch == "a") c = 4'd1;
    if (ch == "c") c = 4'd2;
    if (ch == "g") c = 4'd3;
    if (ch == "t") c = 4'd4;
`endif
    if (comp) begin
      case (c)
        4'd1: c = 4'd4;
        4'd4: c = 4'd1;
        4'd2: c = 4'd3;
        4'd3: c = 4'd2;
        default: c = 4'd0;
      endcase
    end
    return c;
  endfunction

  function automatic logic [IN_W-1:0] rand_word();
    logic [IN_W-1:0] w;
    for (int k = 0; k < B; k++) w[8*k +: 8] = alph[$urandom_range(0, 11)];
    return w;
  endfunction

  task automatic push_expect(input logic [IN_W-1:0] words[$], input int len,
                             input bit comp, input bit rev);
    logic [IN_W-1:0] w;
    int bi, sel;
    for (int i = 0; i < len; i++) begin
      w   = words[i / B];
      bi  = i % B;
      sel = rev ? (B - 1 - bi) : bi;
      sb.push_back({LEN_W'(i), mdl(w[8*sel +: 8], comp)});
    end
  endtask

  // Starts a load, scrambles the inputs that must have been latched, waits for done.
  task automatic do_load(input int len, input bit comp, input bit rev, input int maxcyc,
                         output bit ok);
    @(posedge clk); #1;
    start = 1'b1; seq_len = LEN_W'(len); complement = comp; reverse = rev;
    @(posedge clk); #1;
    start = 1'b0; seq_len = LEN_W'(len + 3); complement = ~comp; reverse = ~rev;
    ok = 1'b0;
    for (int i = 0; i < maxcyc; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    tests++; if (nt_valid !== 1'b0) begin fails++; $display("FAIL rst_nt_valid: got %b required 0", nt_valid); end
    tests++; if (nt_out !== 4'd0) begin fails++; $display("FAIL rst_nt_out: got %0d required 0", nt_out); end
    tests++; if (nt_addr !== '0) begin fails++; $display("FAIL rst_nt_addr: got %0d required 0", nt_addr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b required 0", done); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_end(input string name, input bit ok, input int exp_acc);
    tests++;
    if (!ok) begin fails++; $display("FAIL %s_done: got no done required done pulse", name); end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL %s_missing: got %0d nts outstanding required 0", name, sb.size()); end
    tests++;
    if (accepts != exp_acc) begin fails++; $display("FAIL %s_accepts: got %0d required %0d", name, accepts, exp_acc); end
  endtask

  task automatic test_forward();
    bit ok;
    logic [3:0] e[8];
`ifdef GACT_SEQ_LOADER_SOFTMASK_EN
    e = '{1, 2, 3, 4, 0, 0, 0, 0};
`else
    e = '{1, 2, 3, 4, 0, 1, 2, 3};
`endif
    accepts = 0; check_done_timing = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back({LEN_W'(i), e[i]});
    wq.push_back(64'h6763614E54474341); // bytes 0..7 = "ACGTNacg"
    do_load(8, 1'b0, 1'b0, 100, ok);
    check_end("forward", ok, 1);
  endtask

  task automatic test_revcomp();
    bit ok;
    logic [3:0] e[8];
`ifdef GACT_SEQ_LOADER_SOFTMASK_EN
    e = '{0, 0, 0, 0, 1, 2, 3, 4};
`else
    e = '{2, 3, 4, 0, 1, 2, 3, 4};
`endif
    accepts = 0;
    for (int i = 0; i < 8; i++) sb.push_back({LEN_W'(i), e[i]});
    wq.push_back(64'h6763614E54474341);
    do_load(8, 1'b1, 1'b1, 100, ok);
    check_end("revcomp", ok, 1);
  endtask

  task automatic test_two_words();
    bit ok;
    logic [IN_W-1:0] ws[$];
    for (int i = 0; i < 3; i++) ws.push_back(rand_word());
    accepts = 0;
    push_expect(ws, 10, 1'b0, 1'b0);
    foreach (ws[i]) wq.push_back(ws[i]);
    do_load(10, 1'b0, 1'b0, 200, ok);
    check_end("two_words", ok, 2);
    tests++;
    if (wq.size() != 1) begin fails++; $display("FAIL two_words_extra_fetch: got %0d words left required 1", wq.size()); end
    wq.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [IN_W-1:0] ws[$];
    for (int i = 0; i < 3; i++) ws.push_back(rand_word());
    accepts = 0; toggle_mode = 1'b1;
    push_expect(ws, 20, 1'b1, 1'b1);
    foreach (ws[i]) wq.push_back(ws[i]);
    do_load(20, 1'b1, 1'b1, 400, ok);
    toggle_mode = 1'b0;
    check_end("backpressure", ok, 3);
    ws.delete();
    for (int i = 0; i < 2; i++) ws.push_back(rand_word());
    accepts = 0;
    push_expect(ws, 13, 1'b1, 1'b0);
    foreach (ws[i]) wq.push_back(ws[i]);
    do_load(13, 1'b1, 1'b0, 200, ok);
    check_end("b2b_comp_fwd", ok, 2);
  endtask

  task automatic test_zero_len();
    bit ok;
    check_done_timing = 1'b0;
    wq.push_back(rand_word());
    accepts = 0; inrdy_seen = 0; ntv_seen = 0; done_cnt = 0;
    do_load(0, 1'b0, 1'b0, 20, ok);
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    tests++; if (!ok) begin fails++; $display("FAIL zero_len_done: got no done required done pulse"); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL zero_len_done_cnt: got %0d required 1", done_cnt); end
    tests++; if (inrdy_seen != 0) begin fails++; $display("FAIL zero_len_in_ready: got %0d cycles required 0", inrdy_seen); end
    tests++; if (ntv_seen != 0) begin fails++; $display("FAIL zero_len_nt_valid: got %0d cycles required 0", ntv_seen); end
    tests++; if (wq.size() != 1) begin fails++; $display("FAIL zero_len_consumed: got %0d words left required 1", wq.size()); end
    wq.delete();
    check_done_timing = 1'b1;
  endtask

  task automatic test_rst_mid();
    bit ok;
    logic [IN_W-1:0] ws[$];
    ws.push_back(rand_word());
    push_expect(ws, 8, 1'b0, 1'b0);
    wq.push_back(ws[0]);
    @(posedge clk); #1;
    start = 1'b1; seq_len = LEN_W'(8); complement = 1'b0; reverse = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() <= 5) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL rst_mid_emit: got %0d nts left required <=5", sb.size()); end
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({in_ready, nt_valid, nt_out, nt_addr, busy, done} !== '0) begin
      fails++;
      $display("FAIL rst_mid_outputs: got rdy=%b v=%b nt=%0d addr=%0d busy=%b done=%b required all 0",
               in_ready, nt_valid, nt_out, nt_addr, busy, done);
    end
    sb.delete(); wq.delete(); ws.delete();
    ws.push_back(rand_word());
    push_expect(ws, 8, 1'b1, 1'b0);
    wq.push_back(ws[0]);
    seq_len = LEN_W'(8); complement = 1'b1; reverse = 1'b0;
    accepts = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    #1;
    check_end("rst_reload", ok, 1);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_revcomp();
    test_two_words();
    test_back_to_back();
    test_zero_len();
    test_rst_mid();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion required finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
